// File: rtl/slave_in_port.sv
// Slave-side receive stage: deserializes address, burst length and write data into word writes or a read request.
// Optional range check against MEM_DEPTH is enabled by defining SLAVE_ADDR_CHECK_EN.
module slave_in_port #(
  parameter int SLAVE_ADDR_SIZE = 12,
  parameter int WORD_SIZE       = 8,
  parameter int BURST_SIZE      = 15,
  parameter int MEM_DEPTH       = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sel,
  input  logic                       addr_bus,
  input  logic                       addr_valid,
  input  logic                       burst_size_bus,
  input  logic                       len_valid,
  input  logic                       w_data_bus,
  input  logic                       data_valid,
  input  logic                       read_en,
  input  logic                       burst,
  input  logic                       rd_done,
  output logic                       s_ready,
  output logic [SLAVE_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]       mem_wdata,
  output logic                       mem_we,
  output logic                       rd_req,
  output logic [BURST_SIZE-1:0]      rd_len,
  output logic                       tx_done,
  output logic                       addr_err
);

  localparam int MAX_W = (SLAVE_ADDR_SIZE > WORD_SIZE)
                       ? ((SLAVE_ADDR_SIZE > BURST_SIZE) ? SLAVE_ADDR_SIZE : BURST_SIZE)
                       : ((WORD_SIZE > BURST_SIZE) ? WORD_SIZE : BURST_SIZE);
  localparam int CNT_W = $clog2(MAX_W);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(SLAVE_ADDR_SIZE - 1);
  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(BURST_SIZE - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_SIZE - 1);

  if (MEM_DEPTH < 1 || MEM_DEPTH > (1 << SLAVE_ADDR_SIZE)) begin : g_bad_depth
    $error("slave_in_port: MEM_DEPTH must lie in 1 .. 2**SLAVE_ADDR_SIZE");
  end

  typedef enum logic [2:0] {IDLE, ADDR, LEN, WR, RD, DONE} state_t;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [BURST_SIZE-1:0]      len_q;
  logic [BURST_SIZE-1:0]      word_cnt;
  logic                       rd_flag;
  logic                       wr_pend;
  logic                       rd_block;

  // Shift registers hold only the bits already received; the incoming bit completes the field.
  logic [SLAVE_ADDR_SIZE-2:0] addr_sr;
  logic [BURST_SIZE-2:0]      len_sr;
  logic [WORD_SIZE-2:0]       data_sr;

  logic [SLAVE_ADDR_SIZE-1:0] addr_full;
  logic [BURST_SIZE-1:0]      len_full;
  logic [WORD_SIZE-1:0]       word_full;

  assign addr_full = {addr_bus, addr_sr};
  assign len_full  = {burst_size_bus, len_sr};
  assign word_full = {w_data_bus, data_sr};

  function automatic logic [BURST_SIZE-1:0] norm_len(input logic [BURST_SIZE-1:0] l);
    return (l == '0) ? BURST_SIZE'(1) : l;
  endfunction

`ifdef SLAVE_ADDR_CHECK_EN
  function automatic logic out_of_range(input logic [SLAVE_ADDR_SIZE-1:0] a);
    return ({1'b0, a} >= (SLAVE_ADDR_SIZE + 1)'(MEM_DEPTH));
  endfunction

  // A read whose start address is invalid never reaches the core.
  always_comb begin
    rd_block = addr_err;
    if (state == ADDR) rd_block = out_of_range(addr_full);
  end
`else
  assign rd_block = 1'b0;
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (state == ADDR && addr_valid) addr_sr <= addr_full[SLAVE_ADDR_SIZE-1:1];
    if (state == LEN  && len_valid)  len_sr  <= len_full[BURST_SIZE-1:1];
    if (state == WR   && data_valid) data_sr <= word_full[WORD_SIZE-1:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      word_cnt  <= '0;
      rd_flag   <= 1'b0;
      wr_pend   <= 1'b0;
      s_ready   <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rd_req    <= 1'b0;
      rd_len    <= '0;
      tx_done   <= 1'b0;
`ifdef SLAVE_ADDR_CHECK_EN
      addr_err  <= 1'b0;
`endif
    end else begin
      mem_we  <= 1'b0;
      tx_done <= 1'b0;
      wr_pend <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (sel) begin
            state <= ADDR;
`ifdef SLAVE_ADDR_CHECK_EN
            addr_err <= 1'b0;
`endif
          end
        end

        ADDR: begin
          if (!sel) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (addr_valid) begin
            if (cnt == ADDR_LAST) begin
              cnt      <= '0;
              mem_addr <= addr_full;
              rd_flag  <= read_en;
              word_cnt <= '0;
`ifdef SLAVE_ADDR_CHECK_EN
              addr_err <= out_of_range(addr_full);
`endif
              if (burst) begin
                state <= LEN;
              end else begin
                len_q <= BURST_SIZE'(1);
                if (!read_en) begin
                  state <= WR;
                end else if (rd_block) begin
                  state   <= DONE;
                  tx_done <= 1'b1;
                  s_ready <= 1'b0;
                end else begin
                  state   <= RD;
                  rd_req  <= 1'b1;
                  rd_len  <= BURST_SIZE'(1);
                  s_ready <= 1'b0;
                end
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        LEN: begin
          if (!sel) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (len_valid) begin
            if (cnt == LEN_LAST) begin
              cnt   <= '0;
              len_q <= norm_len(len_full);
              if (!rd_flag) begin
                state <= WR;
              end else if (rd_block) begin
                state   <= DONE;
                tx_done <= 1'b1;
                s_ready <= 1'b0;
              end else begin
                state   <= RD;
                rd_req  <= 1'b1;
                rd_len  <= norm_len(len_full);
                s_ready <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        WR: begin
          if (!sel) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            if (data_valid) begin
              if (cnt == WORD_LAST) begin
                cnt       <= '0;
                mem_wdata <= word_full;
                wr_pend   <= 1'b1;
`ifdef SLAVE_ADDR_CHECK_EN
                mem_we    <= !addr_err;
`else
                mem_we    <= 1'b1;
`endif
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            // Address and word count advance in the cycle the strobe is visible.
            if (wr_pend) begin
              mem_addr <= mem_addr + SLAVE_ADDR_SIZE'(1);
              word_cnt <= word_cnt + BURST_SIZE'(1);
              if (word_cnt + BURST_SIZE'(1) == len_q) begin
                state   <= DONE;
                tx_done <= 1'b1;
                s_ready <= 1'b0;
              end
`ifdef SLAVE_ADDR_CHECK_EN
              else if (out_of_range(mem_addr + SLAVE_ADDR_SIZE'(1))) begin
                addr_err <= 1'b1;
              end
`endif
            end
          end
        end

        RD: begin
          if (rd_done) begin
            rd_req  <= 1'b0;
            tx_done <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          state   <= IDLE;
          cnt     <= '0;
          s_ready <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_in_port.sv
// Directed bench for slave_in_port: single/burst writes, burst read, aborts, gapped bits and reset.
module tb_slave_in_port;

`ifdef SLAVE_ADDR_CHECK_EN
  localparam int DEPTH = 256;
`else
  localparam int DEPTH = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        addr_bus = 1'b0, addr_valid = 1'b0;
  logic        burst_size_bus = 1'b0, len_valid = 1'b0;
  logic        w_data_bus = 1'b0, data_valid = 1'b0;
  logic        read_en = 1'b0, burst = 1'b0, rd_done = 1'b0;
  logic        s_ready;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        rd_req;
  logic [14:0] rd_len;
  logic        tx_done;
  logic        addr_err;

  int errors = 0;
  int checks = 0;

  logic [11:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          tx_cnt = 0;

  slave_in_port #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sel(sel),
    .addr_bus(addr_bus), .addr_valid(addr_valid),
    .burst_size_bus(burst_size_bus), .len_valid(len_valid),
    .w_data_bus(w_data_bus), .data_valid(data_valid),
    .read_en(read_en), .burst(burst), .rd_done(rd_done),
    .s_ready(s_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .rd_req(rd_req), .rd_len(rd_len),
    .tx_done(tx_done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
    if (tx_done) tx_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_addr(input logic [11:0] a, input logic rd, input logic bst, input bit gap);
    for (int i = 0; i < 12; i++) begin
      addr_bus = a[i]; addr_valid = 1'b1; read_en = rd; burst = bst;
      tick();
      addr_valid = 1'b0;
      if (gap && i < 11) begin
        addr_bus = ~a[i]; data_valid = 1'b1; len_valid = 1'b1; w_data_bus = 1'b1;
        tick();
        data_valid = 1'b0; len_valid = 1'b0;
      end
    end
    read_en = 1'b0; burst = 1'b0;
  endtask

  task automatic send_len(input logic [14:0] l, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      burst_size_bus = l[i]; len_valid = 1'b1;
      tick();
    end
    len_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int drop_at);
    for (int i = 0; i < 8; i++) begin
      w_data_bus = w[i]; data_valid = 1'b1;
      if (i == drop_at) sel = 1'b0;
      tick();
      if (i == drop_at) break;
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    while (!tx_done && n < 100) begin
      tick();
      n++;
    end
    check_val(tag, tx_done, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_s_ready"}, s_ready, 1'b1);
    check_val({tag, "_mem_addr"}, mem_addr, 12'h000);
    check_val({tag, "_mem_wdata"}, mem_wdata, 8'h00);
    check_val({tag, "_mem_we"}, mem_we, 1'b0);
    check_val({tag, "_rd_req"}, rd_req, 1'b0);
    check_val({tag, "_rd_len"}, rd_len, 15'd0);
    check_val({tag, "_tx_done"}, tx_done, 1'b0);
    check_val({tag, "_addr_err"}, addr_err, 1'b0);
  endtask

  initial begin
    int wbase, tbase;

    tick(); tick();
    rst = 1'b0;
    tick();
    check_reset_state("reset");

    // Single write 0x0A5 <= 0x3C
    wbase = wa_q.size(); tbase = tx_cnt;
    sel = 1'b1; tick();
    send_addr(12'h0A5, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, -1);
    check_val("sw_we", mem_we, 1'b1);
    check_val("sw_addr", mem_addr, 12'h0A5);
    check_val("sw_data", mem_wdata, 8'h3C);
    check_val("sw_no_early_done", tx_done, 1'b0);
    tick();
    check_val("sw_tx_done", tx_done, 1'b1);
    check_val("sw_we_once", mem_we, 1'b0);
    check_val("sw_not_ready_done", s_ready, 1'b0);
    sel = 1'b0;
    tick();
    check_val("sw_done_pulse", tx_done, 1'b0);
    check_val("sw_ready_idle", s_ready, 1'b1);
    check_val("sw_n_writes", wa_q.size() - wbase, 1);
    check_val("sw_n_done", tx_cnt - tbase, 1);

`ifndef SLAVE_ADDR_CHECK_EN
    // Burst write crossing the top of the address space
    wbase = wa_q.size(); tbase = tx_cnt;
    sel = 1'b1; tick();
    send_addr(12'hFFE, 1'b0, 1'b1, 1'b0);
    send_len(15'd3, 15);
    send_word(8'h11, -1);
    send_word(8'h22, -1);
    send_word(8'h33, -1);
    wait_tx("bw_tx_done");
    sel = 1'b0;
    tick(); tick();
    check_val("bw_n_writes", wa_q.size() - wbase, 3);
    if (wa_q.size() - wbase == 3) begin
      check_val("bw_a0", wa_q[wbase], 12'hFFE);
      check_val("bw_d0", wd_q[wbase], 8'h11);
      check_val("bw_a1", wa_q[wbase+1], 12'hFFF);
      check_val("bw_d1", wd_q[wbase+1], 8'h22);
      check_val("bw_a2", wa_q[wbase+2], 12'h000);
      check_val("bw_d2", wd_q[wbase+2], 8'h33);
    end
    check_val("bw_n_done", tx_cnt - tbase, 1);
`endif

    // Burst read of 5 words at 0x010
    tbase = tx_cnt;
    sel = 1'b1; tick();
    send_addr(12'h010, 1'b1, 1'b1, 1'b0);
    send_len(15'd5, 15);
    check_val("rd_req", rd_req, 1'b1);
    check_val("rd_len", rd_len, 15'd5);
    check_val("rd_addr", mem_addr, 12'h010);
    check_val("rd_not_ready", s_ready, 1'b0);
    sel = 1'b0;
    tick(); tick(); tick();
    check_val("rd_req_held", rd_req, 1'b1);
    check_val("rd_sel_ignored", tx_done, 1'b0);
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    check_val("rd_req_drop", rd_req, 1'b0);
    check_val("rd_tx_done", tx_done, 1'b1);
    tick();
    check_val("rd_ready_after", s_ready, 1'b1);
    check_val("rd_n_done", tx_cnt - tbase, 1);

    // Abort on the 4th data bit
    wbase = wa_q.size(); tbase = tx_cnt;
    sel = 1'b1; tick();
    send_addr(12'h123, 1'b0, 1'b0, 1'b0);
    send_word(8'hFF, 3);
    check_val("ab4_ready", s_ready, 1'b1);
    tick(); tick(); tick();
    check_val("ab4_no_we", wa_q.size() - wbase, 0);
    check_val("ab4_no_done", tx_cnt - tbase, 0);

    // Abort coinciding with the final data bit
    sel = 1'b1; tick();
    send_addr(12'h321, 1'b0, 1'b0, 1'b0);
    send_word(8'h5A, 7);
    tick(); tick(); tick();
    check_val("ab8_no_we", wa_q.size() - wbase, 0);
    check_val("ab8_no_done", tx_cnt - tbase, 0);
    check_val("ab8_ready", s_ready, 1'b1);

    // Gapped address bits with wrong-phase qualifiers in the gaps
    sel = 1'b1; tick();
    send_addr(12'h5A3, 1'b1, 1'b0, 1'b1);
    check_val("gap_addr", mem_addr, 12'h5A3);
    check_val("gap_rd_req", rd_req, 1'b1);
    check_val("gap_rd_len", rd_len, 15'd1);
    sel = 1'b0;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    tick();

    // Reset in the middle of the length field
    sel = 1'b1; tick();
    send_addr(12'h0F0, 1'b0, 1'b1, 1'b0);
    send_len(15'd7, 5);
    rst = 1'b1; sel = 1'b0; tick();
    rst = 1'b0;
    check_reset_state("midrst");
    tick();

    // Fresh transaction after reset assembles cleanly
    wbase = wa_q.size();
    sel = 1'b1; tick();
    send_addr(12'h7FF, 1'b0, 1'b0, 1'b0);
    send_word(8'hA5, -1);
    check_val("post_we", mem_we, 1'b1);
    check_val("post_addr", mem_addr, 12'h7FF);
    check_val("post_data", mem_wdata, 8'hA5);
    wait_tx("post_tx_done");
    sel = 1'b0;
    tick(); tick();
    check_val("post_n_writes", wa_q.size() - wbase, 1);

`ifdef SLAVE_ADDR_CHECK_EN
    // Burst write running past MEM_DEPTH
    wbase = wa_q.size(); tbase = tx_cnt;
    sel = 1'b1; tick();
    send_addr(12'h0FF, 1'b0, 1'b1, 1'b0);
    send_len(15'd2, 15);
    send_word(8'h44, -1);
    send_word(8'h55, -1);
    wait_tx("chk_tx_done");
    check_val("chk_err", addr_err, 1'b1);
    sel = 1'b0;
    tick(); tick();
    check_val("chk_n_writes", wa_q.size() - wbase, 1);
    if (wa_q.size() - wbase == 1) begin
      check_val("chk_a0", wa_q[wbase], 12'h0FF);
      check_val("chk_d0", wd_q[wbase], 8'h44);
    end
    check_val("chk_n_done", tx_cnt - tbase, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
